// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality for alu_share_ctrl.
package alu_share_ctrl_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester and ALU-side bundle for alu_share_ctrl; slave = controller, master = environment.
interface alu_share_ctrl_if;
  logic        req0, req1;
  logic [2:0]  sel0, sel1;
  logic [31:0] a0, b0, a1, b1;
  logic        ack0, ack1, done0, done1, err;
  logic [31:0] res_out;
  logic        z_out, c_out, v_out, busy;
  logic [2:0]  alu_sel;
  logic [31:0] alu_opA, alu_opB;
  logic [31:0] alu_res;
  logic        alu_z, alu_c, alu_v;
  logic        flag_err;

  modport slave (
    input  req0, req1, sel0, sel1, a0, b0, a1, b1, alu_res, alu_z, alu_c, alu_v,
    output ack0, ack1, done0, done1, err, res_out, z_out, c_out, v_out, busy,
           alu_sel, alu_opA, alu_opB, flag_err
  );

  modport master (
    output req0, req1, sel0, sel1, a0, b0, a1, b1, alu_res, alu_z, alu_c, alu_v,
    input  ack0, ack1, done0, done1, err, res_out, z_out, c_out, v_out, busy,
           alu_sel, alu_opA, alu_opB, flag_err
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer holds the index granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);
  // On a tie the requester that was not granted last wins.
  assign grant[0] = req[0] & (~req[1] | pointer);
  assign grant[1] = req[1] & (~req[0] | ~pointer);
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters (IDLE -> ISSUE -> WAIT).
// Optional flag-consistency checker enabled by defining ALU_SHARE_FLAG_CHECK_EN.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
(
  input  logic             elk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus
);

  state_t      state_q;
  logic        rr_q, tgt_q;
  logic        ack0_q, ack1_q, done0_q, done1_q, err_q, busy_q;
  logic [31:0] res_q;
  logic        z_q, c_q, v_q;
  logic [2:0]  alu_sel_q;
  logic [31:0] alu_opA_q, alu_opB_q;

  logic [1:0]  gnt_d;
  logic [2:0]  sel_d;
  logic [31:0] a_d, b_d;
  logic        legal_d;

  rr_arb2 u_arb (
    .req     ({bus.req1, bus.req0}),
    .pointer (rr_q),
    .grant   (gnt_d)
  );

  always_comb begin
    sel_d   = gnt_d[1] ? bus.sel1 : bus.sel0;
    a_d     = gnt_d[1] ? bus.a1   : bus.a0;
    b_d     = gnt_d[1] ? bus.b1   : bus.b0;
    legal_d = op_legal(sel_d);
  end

  always_ff @(posedge elk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b1;
      tgt_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      res_q     <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      alu_sel_q <= OP_NOP;
      alu_opA_q <= '0;
      alu_opB_q <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt_d) begin
            rr_q   <= gnt_d[1];
            tgt_q  <= gnt_d[1];
            ack0_q <= gnt_d[0];
            ack1_q <= gnt_d[1];
            if (legal_d) begin
              state_q   <= ST_ISSUE;
              busy_q    <= 1'b1;
              alu_sel_q <= sel_d;
              alu_opA_q <= a_d;
              alu_opB_q <= b_d;
            end else begin
              // Illegal opcode completes immediately; the ALU is never touched.
              done0_q <= gnt_d[0];
              done1_q <= gnt_d[1];
              err_q   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q   <= ST_WAIT;
          alu_sel_q <= OP_NOP;
          alu_opA_q <= '0;
          alu_opB_q <= '0;
        end
        ST_WAIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          res_q   <= bus.alu_res;
          z_q     <= bus.alu_z;
          c_q     <= bus.alu_c;
          v_q     <= bus.alu_v;
          done0_q <= ~tgt_q;
          done1_q <= tgt_q;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SHARE_FLAG_CHECK_EN
  logic flag_err_q;
  logic flag_bad;

  // The shared ALU only runs logic ops, so carry/overflow must stay clear.
  assign flag_bad = (bus.alu_z != (bus.alu_res == 32'd0)) | bus.alu_c | bus.alu_v;

  always_ff @(posedge elk or posedge rst) begin
    if (rst) begin
      flag_err_q <= 1'b0;
    end else if (state_q == ST_WAIT && flag_bad) begin
      flag_err_q <= 1'b1;
    end
  end

  assign bus.flag_err = flag_err_q;
`else
  assign bus.flag_err = 1'b0;
`endif

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.res_out = res_q;
  assign bus.z_out   = z_q;
  assign bus.c_out   = c_q;
  assign bus.v_out   = v_q;
  assign bus.alu_sel = alu_sel_q;
  assign bus.alu_opA = alu_opA_q;
  assign bus.alu_opB = alu_opB_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a registered ALU model.
// Flag-checker expectations follow ALU_SHARE_FLAG_CHECK_EN.
module tb_alu_share_ctrl;

  logic elk = 1'b0;
  logic rst = 1'b1;
  always #5 elk = ~elk;

  alu_share_ctrl_if bus_if ();

  alu_share_ctrl dut (
    .elk (elk),
    .rst (rst),
    .bus (bus_if)
  );

  int   checks = 0;
  int   errors = 0;
  logic bad_z  = 1'b0;
  logic mon_en = 1'b0;
  logic sel_seen = 1'b0;

  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      default: return a;
    endcase
  endfunction

  // Registered ALU: holds its outputs while alu_sel is 000.
  always @(posedge elk) begin
    if (rst) begin
      bus_if.alu_res <= 32'd0;
      bus_if.alu_z   <= 1'b1;
      bus_if.alu_c   <= 1'b0;
      bus_if.alu_v   <= 1'b0;
    end else if (bus_if.alu_sel != 3'b000) begin
      bus_if.alu_res <= alu_f(bus_if.alu_sel, bus_if.alu_opA, bus_if.alu_opB);
      bus_if.alu_z   <= bad_z ? 1'b0 : (alu_f(bus_if.alu_sel, bus_if.alu_opA, bus_if.alu_opB) == 32'd0);
    end
    if (mon_en && bus_if.alu_sel != 3'b000) sel_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge elk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {19'd0, bus_if.ack0, bus_if.ack1, bus_if.done0, bus_if.done1, bus_if.err,
                        bus_if.busy, bus_if.flag_err, bus_if.z_out, bus_if.c_out, bus_if.v_out,
                        bus_if.alu_sel}, 32'd0);
    chk({tag, "_res"}, bus_if.res_out, 32'd0);
    chk({tag, "_opa"}, bus_if.alu_opA, 32'd0);
    chk({tag, "_opb"}, bus_if.alu_opB, 32'd0);
  endtask

  logic done_seen;
  int   n;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    bus_if.sel0 = 3'b000; bus_if.sel1 = 3'b000;
    bus_if.a0 = '0; bus_if.b0 = '0; bus_if.a1 = '0; bus_if.b1 = '0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Tie straight after reset: req0 first, then req1.
    bus_if.sel0 = 3'b011; bus_if.a0 = 32'h0; bus_if.b0 = 32'h0;
    bus_if.sel1 = 3'b100; bus_if.a1 = 32'hFFFF_FFFF; bus_if.b1 = 32'h0;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    tick();
    chk("tie_ack", {30'd0, bus_if.ack1, bus_if.ack0}, 32'd1);
    chk("tie_busy", {31'd0, bus_if.busy}, 32'd1);
    chk("tie_sel0", {29'd0, bus_if.alu_sel}, 32'd3);
    bus_if.req0 = 1'b0;
    tick();
    chk("tie_sel_nop", {29'd0, bus_if.alu_sel}, 32'd0);
    tick();
    chk("tie_done0", {29'd0, bus_if.done1, bus_if.done0, bus_if.err}, 32'b010);
    chk("tie_res0", {bus_if.res_out[30:0], bus_if.z_out}, 32'd1);
    tick();
    chk("tie_ack1", {30'd0, bus_if.ack1, bus_if.ack0}, 32'd2);
    chk("tie_opa1", bus_if.alu_opA, 32'hFFFF_FFFF);
    chk("tie_sel1", {29'd0, bus_if.alu_sel}, 32'd4);
    bus_if.req1 = 1'b0;
    tick(); tick();
    chk("tie_done1", {29'd0, bus_if.done1, bus_if.done0, bus_if.err}, 32'b100);
    chk("tie_res1", bus_if.res_out, 32'h0);
    chk("tie_z1", {31'd0, bus_if.z_out}, 32'd1);
    tick();

    // Next tie goes back to req0; req1 dropped before it is ever sampled.
    bus_if.sel0 = 3'b010; bus_if.a0 = 32'h1234_5678; bus_if.b0 = 32'hFF00_FF00;
    bus_if.sel1 = 3'b011;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    tick();
    chk("tie2_ack", {30'd0, bus_if.ack1, bus_if.ack0}, 32'd1);
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    tick(); tick();
    chk("tie2_res", bus_if.res_out, 32'h1200_5600);
    tick();
    chk("tie2_noack1", {30'd0, bus_if.ack1, bus_if.ack0}, 32'd0);

    // Single req0 AND.
    bus_if.sel0 = 3'b010; bus_if.a0 = 32'hF0F0_F0F0; bus_if.b0 = 32'h0FF0_0FF0;
    bus_if.req0 = 1'b1;
    tick();
    chk("and_ack0", {31'd0, bus_if.ack0}, 32'd1);
    chk("and_opa", bus_if.alu_opA, 32'hF0F0_F0F0);
    chk("and_opb", bus_if.alu_opB, 32'h0FF0_0FF0);
    bus_if.req0 = 1'b0;
    tick();
    chk("and_early", {30'd0, bus_if.done0, bus_if.ack0}, 32'd0);
    tick();
    chk("and_done0", {31'd0, bus_if.done0}, 32'd1);
    chk("and_res", bus_if.res_out, 32'h00F0_00F0);
    chk("and_z", {31'd0, bus_if.z_out}, 32'd0);
    tick();
    chk("and_done_pulse", {31'd0, bus_if.done0}, 32'd0);

    // Illegal opcode from req1.
    mon_en = 1'b1;
    bus_if.sel1 = 3'b111; bus_if.a1 = 32'hDEAD_BEEF; bus_if.b1 = 32'h1;
    bus_if.req1 = 1'b1;
    tick();
    chk("ill_pulse", {29'd0, bus_if.ack1, bus_if.done1, bus_if.err}, 32'b111);
    chk("ill_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("ill_res", bus_if.res_out, 32'h00F0_00F0);
    bus_if.req1 = 1'b0;
    tick();
    chk("ill_clear", {29'd0, bus_if.ack1, bus_if.done1, bus_if.err}, 32'd0);
    tick();
    mon_en = 1'b0;
    chk("ill_alu_sel", {31'd0, sel_seen}, 32'd0);

    // Reset during WAIT discards the op.
    bus_if.sel0 = 3'b011; bus_if.a0 = 32'hAAAA_0000; bus_if.b0 = 32'h0000_5555;
    bus_if.req0 = 1'b1;
    tick();
    bus_if.req0 = 1'b0;
    tick();
    chk("rstw_busy", {31'd0, bus_if.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rstw");
    tick();
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      done_seen = done_seen | bus_if.done0 | bus_if.done1;
    end
    chk("rstw_nodone", {31'd0, done_seen}, 32'd0);
    bus_if.sel1 = 3'b011; bus_if.a1 = 32'h0000_00FF; bus_if.b1 = 32'h0F00_0000;
    bus_if.req1 = 1'b1;
    tick();
    chk("rstw_ack1", {31'd0, bus_if.ack1}, 32'd1);
    bus_if.req1 = 1'b0;
    tick(); tick();
    chk("rstw_done1", {31'd0, bus_if.done1}, 32'd1);
    chk("rstw_res", bus_if.res_out, 32'h0F00_00FF);
    tick();

    // Both held continuously: strict alternation with one idle cycle between ops.
    bus_if.sel0 = 3'b010; bus_if.a0 = 32'hFFFF_0000; bus_if.b0 = 32'h0F0F_0F0F;
    bus_if.sel1 = 3'b011; bus_if.a1 = 32'h0000_00F0; bus_if.b1 = 32'h0000_000F;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus_if.ack0 | bus_if.ack1) && n < 8);
    chk("rr_start", {31'd0, (n < 8)}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_ack%0d", k), {30'd0, bus_if.ack1, bus_if.ack0}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("rr_busy%0d", k), {31'd0, bus_if.busy}, 32'd1);
      tick(); tick();
      chk($sformatf("rr_gap%0d", k), {31'd0, bus_if.busy}, 32'd0);
      chk($sformatf("rr_done%0d", k), {30'd0, bus_if.done1, bus_if.done0}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("rr_res%0d", k), bus_if.res_out, (k % 2) ? 32'h0000_00FF : 32'h0F0F_0000);
      if (k == 5) begin
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
      end
      tick();
    end
    chk("rr_end", {29'd0, bus_if.ack1, bus_if.ack0, bus_if.busy}, 32'd0);
    chk("flag_clean", {31'd0, bus_if.flag_err}, 32'd0);

    // ALU reports z=0 with a zero result.
    bad_z = 1'b1;
    bus_if.sel0 = 3'b010; bus_if.a0 = 32'h0; bus_if.b0 = 32'h0;
    bus_if.req0 = 1'b1;
    tick();
    bus_if.req0 = 1'b0;
    tick();
    chk("flag_before", {31'd0, bus_if.flag_err}, 32'd0);
    tick();
    chk("flag_done", {31'd0, bus_if.done0}, 32'd1);
`ifdef ALU_SHARE_FLAG_CHECK_EN
    chk("flag_set", {31'd0, bus_if.flag_err}, 32'd1);
    tick(); tick(); tick();
    chk("flag_sticky", {31'd0, bus_if.flag_err}, 32'd1);
`else
    chk("flag_tied", {31'd0, bus_if.flag_err}, 32'd0);
    tick(); tick(); tick();
    chk("flag_tied_later", {31'd0, bus_if.flag_err}, 32'd0);
`endif
    bad_z = 1'b0;
    rst = 1'b1;
    #1;
    chk("flag_rst", {31'd0, bus_if.flag_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning:
- elk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1 each  request from requester 0/1, held until ack.
- sel0, sel1  in  3 each  opcode from requester 0/1.
- a0, b0, a1, b1  in  32 each  operands from requester 0/1.
- ack0, ack1  out  1 each  request accepted; one-cycle pulse.
- done0, done1  out  1 each  result valid; one-cycle pulse.
- err  out  1  illegal opcode; valid with done.
- res_out  out  32  result.
- z_out, c_out, v_out  out  1 each  flags.
- busy  out  1  state is not IDLE.
- alu_sel  out  3  opcode to the ALU.
- alu_opA, alu_opB  out  32 each  operands to the ALU.
- alu_res  in  32  ALU result, registered inside the ALU.
- alu_z, alu_c, alu_v  in  1 each  ALU flags.
- flag_err  out  1  sticky flag-consistency error.

REQ-002 SHALL use one clock and one reset; reset SHALL be asynchronous and active-high, named rst, with clock named elk.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.

REQ-005 In IDLE, at a rising edge with any reqN high, SHALL grant exactly one requester:
- Only one request high: grant it.
- Both high: grant the requester not granted last (round-robin).

REQ-006 On grant, SHALL latch selN, aN and bN, and pulse ackN for the following cycle.

REQ-007 Legal opcodes SHALL be 3'b010 (AND), 3'b011 (OR) and 3'b100 (NOT A); all other values are illegal.

REQ-008 On a grant with an illegal opcode, SHALL:
- pulse ackN, doneN and err together in the following cycle;
- leave res_out and the flags unchanged;
- stay in IDLE and not drive the ALU.
The round-robin pointer SHALL still update.

REQ-009 On a grant with a legal opcode, SHALL go to ISSUE; in ISSUE, alu_sel/alu_opA/alu_opB SHALL equal the latched values.

REQ-010 From ISSUE, SHALL go to WAIT at the next edge; the ALU captures the operands at that edge.

REQ-011 At the edge leaving WAIT, SHALL:
- capture alu_res/alu_z/alu_c/alu_v into res_out/z_out/c_out/v_out;
- pulse doneN with err=0;
- return to IDLE.

REQ-012 Latency SHALL be fixed:
- Legal op: request sampled at edge E gives done high from edge E+2 to E+3.
- Next request sampled no earlier than E+3.

REQ-013 Outside ISSUE, alu_sel SHALL be 3'b000 so the ALU holds its state; alu_opA/alu_opB SHALL be 0.

REQ-014 Request handling SHALL meet the following rules:
- reqN SHALL be ignored in ISSUE and WAIT.
- Operands need only be stable at the sampling edge.
- A request dropped before sampling SHALL produce no ack.

REQ-015 busy SHALL be high in ISSUE and WAIT.

Reset
REQ-016 While rst is high, SHALL force:
- state = IDLE;
- ack0/ack1/done0/done1/err/busy/flag_err = 0;
- res_out = 0, z_out/c_out/v_out = 0;
- alu_sel = 0, alu_opA = 0, alu_opB = 0;
- round-robin pointer = 1, so req0 wins the first tie.

REQ-017 Reset during ISSUE or WAIT SHALL discard the operation; no done SHALL be emitted for it.

Configuration
REQ-018 With ALU_SHARE_FLAG_CHECK_EN defined, at the WAIT edge SHALL set flag_err (sticky until reset) if any of the following holds:
- alu_z differs from (alu_res == 0);
- alu_c is 1;
- alu_v is 1.

REQ-019 Without ALU_SHARE_FLAG_CHECK_EN, flag_err SHALL be tied to 0 and the check logic SHALL be absent.

Structure
REQ-020 A shared package SHALL hold:
- the opcode constants OP_AND = 3'b010, OP_OR = 3'b011, OP_NOT = 3'b100 and OP_NOP = 3'b000;
- the FSM state encoding.

REQ-021 Round-robin selection SHALL be a sub-module rr_arb2 with inputs req[1:0] and pointer and a one-hot grant output.

Verification
REQ-022 Bench SHALL cover:
- req0 only, sel=010, a=0xF0F0_F0F0, b=0x0FF0_0FF0 -> ack0 at E+1, done0 at E+2, res_out=0x00F0_00F0, z=0.
- req0 and req1 together: req0 sel=011 a=0 b=0; req1 sel=100 a=0xFFFF_FFFF -> req0 served first (res 0, z=1), then req1 (res 0, z=1); next tie goes to req0.
- req1 only, sel=111 -> ack1, done1 and err pulse together; ALU never sees a nonzero alu_sel; res_out unchanged.
- rst asserted during WAIT of a req0 op -> no done0; all outputs at reset values; a later req1 completes normally.
- Both requests held continuously for 6 ops -> grants alternate 0,1,0,1,0,1; busy low exactly one cycle between ops.
- ALU_SHARE_FLAG_CHECK_EN defined, ALU model forces alu_z=0 with alu_res=0 -> flag_err rises at the done edge and stays high until rst.
